conbox_cfg_loader: RTL and testbench

CONBOX_CFG_LOADER -- requirements
Module: conbox_cfg_loader

---
 rtl/conbox_cfg_pkg.sv | 33 +++
 rtl/conbox_cfg_loader.sv | 188 ++++++++++++++++++
 tb/tb_conbox_cfg_loader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/conbox_cfg_pkg.sv
// conbox_cfg_pkg
//   Shared types and helpers for the conbox configuration loader.
//   - cfg_state_e     : loader FSM state encoding
//   - tie_low_pattern : reset value for a vector of select fields where
//                       every field selects "WIDTH", i.e. no track driven
// Optional feature macro used by the loader: CONBOX_CFG_PARITY_EN
package conbox_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_COMMIT = 2'd3
  } cfg_state_e;

  // Upper bound on the configuration word the helper can build.
  localparam int MAX_CFG_W = 512;

  // Each field is clog2(width+2) bits wide and holds the value width.
  function automatic logic [MAX_CFG_W-1:0] tie_low_pattern(input int width, input int fields);
    int                   sel_bits;
    logic [MAX_CFG_W-1:0] pat;
    logic [MAX_CFG_W-1:0] fld;
    sel_bits = $clog2(width + 2);
    pat      = {MAX_CFG_W{1'b0}};
    fld      = MAX_CFG_W'(width);
    for (int f = 0; f < fields; f++) begin
      pat = pat | (fld << (f * sel_bits));
    end
    return pat;
  endfunction

endpackage

// File: rtl/conbox_cfg_loader.sv
// conbox_cfg_loader
//   Serial configuration loader for a connection box. Bits are shifted into
//   a shadow register (bit k of the stream lands in shadow[k]) and committed
//   atomically to the side A / side B select outputs, so the connection box
//   never sees a half-written configuration.
//
// Ports
//   clk          : single clock, rising edge
//   rst          : synchronous active-high reset, highest priority
//   cfg_start    : one-cycle load request (only honoured in IDLE)
//   cfg_abort    : cancel a load in SHIFT / PARITY
//   cfg_bit      : serial data bit
//   cfg_valid    : cfg_bit is valid
//   cfg_ready    : loader accepts cfg_bit this cycle
//   config_dataA : committed select fields, side A (shadow[CFG_W-1:0])
//   config_dataB : committed select fields, side B (shadow[N-1:CFG_W])
//   cfg_busy     : loader is not IDLE
//   cfg_done     : one-cycle pulse after a commit
//   cfg_err      : sticky parity error (cleared by cfg_start or rst)
//   config_valid : at least one commit since reset
//
// Optional feature: define CONBOX_CFG_PARITY_EN to require a trailing even
// parity bit (XOR of all data bits) before commit. Without it cfg_err is 0.
module conbox_cfg_loader
  import conbox_cfg_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LE_INPUTS  = 4,
  parameter int LE_OUTPUTS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic cfg_start,
  input  logic cfg_abort,
  input  logic cfg_bit,
  input  logic cfg_valid,
  output logic cfg_ready,
  output logic [$clog2(WIDTH+2)*(LE_INPUTS+LE_OUTPUTS)-1:0] config_dataA,
  output logic [$clog2(WIDTH+2)*(LE_INPUTS+LE_OUTPUTS)-1:0] config_dataB,
  output logic cfg_busy,
  output logic cfg_done,
  output logic cfg_err,
  output logic config_valid
);

  localparam int SEL_BITS = $clog2(WIDTH + 2);
  localparam int CFG_W    = SEL_BITS * (LE_INPUTS + LE_OUTPUTS);
  localparam int N        = 2 * CFG_W;
  localparam int CNT_W    = $clog2(N + 1);

  localparam logic [CFG_W-1:0] RST_PAT =
    CFG_W'(tie_low_pattern(WIDTH, LE_INPUTS + LE_OUTPUTS));

  cfg_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]       shadow_q, shadow_d;
  logic [CFG_W-1:0]   data_a_q, data_b_q;
  logic               ready_q, busy_q, done_q, valid_q, err_q;
  logic               accept_s;
  logic               commit_s;
`ifdef CONBOX_CFG_PARITY_EN
  logic               err_set_s;
  logic               err_clr_s;
`endif

  // ready_q mirrors "state is SHIFT or PARITY", so this is the handshake.
  assign accept_s = cfg_valid && ready_q;

  // Next-state, shadow-write and commit decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    commit_s  = 1'b0;
`ifdef CONBOX_CFG_PARITY_EN
    err_set_s = 1'b0;
    err_clr_s = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          state_d   = ST_SHIFT;
          cnt_d     = {CNT_W{1'b0}};
`ifdef CONBOX_CFG_PARITY_EN
          err_clr_s = 1'b1;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // Abort wins over a bit arriving on the same edge.
        if (cfg_abort) begin
          state_d = ST_IDLE;
        end else if (accept_s && (cnt_q < CNT_W'(N))) begin
          shadow_d[cnt_q] = cfg_bit;
          cnt_d           = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(N - 1)) begin
`ifdef CONBOX_CFG_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_COMMIT;
`endif
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
`ifdef CONBOX_CFG_PARITY_EN
      ST_PARITY: begin
        if (cfg_abort) begin
          state_d = ST_IDLE;
        end else if (accept_s) begin
          if (cfg_bit == (^shadow_q)) begin
            state_d = ST_COMMIT;
          end else begin
            state_d   = ST_IDLE;
            err_set_s = 1'b1;
          end
        end else begin
          state_d = ST_PARITY;
        end
      end
`endif
      ST_COMMIT: begin
        state_d  = ST_IDLE;
        commit_s = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, shadow and registered status/output update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      shadow_q <= {N{1'b0}};
      data_a_q <= RST_PAT;
      data_b_q <= RST_PAT;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      ready_q  <= (state_d == ST_SHIFT) || (state_d == ST_PARITY);
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= commit_s;
      if (commit_s) begin
        data_a_q <= shadow_q[CFG_W-1:0];
        data_b_q <= shadow_q[N-1:CFG_W];
        valid_q  <= 1'b1;
      end else begin
        data_a_q <= data_a_q;
        data_b_q <= data_b_q;
        valid_q  <= valid_q;
      end
`ifdef CONBOX_CFG_PARITY_EN
      if (err_clr_s) begin
        err_q <= 1'b0;
      end else if (err_set_s) begin
        err_q <= 1'b1;
      end else begin
        err_q <= err_q;
      end
`else
      err_q <= 1'b0;
`endif
    end
  end

  assign cfg_ready    = ready_q;
  assign cfg_busy     = busy_q;
  assign cfg_done     = done_q;
  assign cfg_err      = err_q;
  assign config_valid = valid_q;
  assign config_dataA = data_a_q;
  assign config_dataB = data_b_q;

endmodule

// File: tb/tb_conbox_cfg_loader.sv
// Directed self-checking bench for conbox_cfg_loader (default parameters).
// Honours CONBOX_CFG_PARITY_EN when the RTL is built with it.
module tb_conbox_cfg_loader;

  localparam int CW = 20;
  localparam int N  = 40;
`ifdef CONBOX_CFG_PARITY_EN
  localparam int NB    = N + 1;
  localparam int LAT_C = 42;
  localparam int LAT_G = 82;
`else
  localparam int NB    = N;
  localparam int LAT_C = 41;
  localparam int LAT_G = 80;
`endif
  localparam logic [CW-1:0] TIE = 20'h88888;

  logic clk = 1'b0;
  logic rst, cfg_start, cfg_abort, cfg_bit, cfg_valid;
  logic cfg_ready, cfg_busy, cfg_done, cfg_err, config_valid;
  logic [CW-1:0] config_dataA, config_dataB;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  conbox_cfg_loader #(.WIDTH(8), .LE_INPUTS(4), .LE_OUTPUTS(1)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_bit(cfg_bit), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .config_dataA(config_dataA), .config_dataB(config_dataB),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .config_valid(config_valid)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one load starting with cfg_start. u counts edges after the start
  // edge. lat = edge index at which cfg_done is first seen (-1 if never).
  task automatic run_load(input logic [CW-1:0] a, input logic [CW-1:0] b,
                          input bit gappy, input bit bad_par,
                          input int restart_at, input int abort_at, input int rst_at,
                          input int max_e,
                          output int lat, output bit stable,
                          output logic ready_mid, output logic busy_evt);
    logic [2*CW-1:0] s;
    logic            par;
    logic [CW-1:0]   prev_a, prev_b;
    int              sent;
    bit              stopped;
    bit              rst_hit;
    s         = {b, a};
    par       = ^s;
    if (bad_par) par = ~par;
    prev_a    = config_dataA;
    prev_b    = config_dataB;
    lat       = -1;
    stable    = 1'b1;
    ready_mid = 1'bx;
    busy_evt  = 1'bx;
    sent      = 0;
    stopped   = 1'b0;
    rst_hit   = 1'b0;
    cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    for (int u = 1; u <= max_e; u++) begin
      cfg_valid = !stopped && (sent < NB) && (!gappy || (u % 2 == 1));
      cfg_bit   = (sent < N) ? s[sent] : par;
      cfg_start = (u == restart_at);
      cfg_abort = (u == abort_at);
      rst       = (u == rst_at);
      tick;
      if (cfg_valid) sent++;
      cfg_start = 1'b0;
      cfg_abort = 1'b0;
      rst       = 1'b0;
      if (u == rst_at) rst_hit = 1'b1;
      if (u == abort_at || u == rst_at) begin
        stopped  = 1'b1;
        busy_evt = cfg_busy;
      end
      if (u == 5) ready_mid = cfg_ready;
      if (cfg_done === 1'b1) begin
        lat = u;
        break;
      end
      if (!rst_hit && ((config_dataA !== prev_a) || (config_dataB !== prev_b))) stable = 1'b0;
    end
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
  endtask

  initial begin
    int   lat;
    bit   stable;
    logic rdy, bsy;

    rst = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_bit = 1'b0; cfg_valid = 1'b0;
    repeat (3) tick;
    rst = 1'b0;
    chk("rst_dataA", config_dataA, TIE);
    chk("rst_dataB", config_dataB, TIE);
    chk("rst_ready", cfg_ready, 1'b0);
    chk("rst_busy", cfg_busy, 1'b0);
    chk("rst_done", cfg_done, 1'b0);
    chk("rst_err", cfg_err, 1'b0);
    chk("rst_cvalid", config_valid, 1'b0);

    // Continuous load.
    run_load(20'h12345, 20'hABCDE, 1'b0, 1'b0, 0, 0, 0, 60, lat, stable, rdy, bsy);
    chk("c_latency", lat, LAT_C);
    chk("c_dataA", config_dataA, 20'h12345);
    chk("c_dataB", config_dataB, 20'hABCDE);
    chk("c_cvalid", config_valid, 1'b1);
    chk("c_busy_at_done", cfg_busy, 1'b0);
    chk("c_no_partial", stable, 1'b1);
    chk("c_ready_mid", rdy, 1'b1);
    chk("c_err", cfg_err, 1'b0);
    tick;
    chk("c_done_one_cycle", cfg_done, 1'b0);

    // Second load, with a stray cfg_start mid-stream that must be ignored.
    run_load(20'h0F0F0, 20'h5A5A5, 1'b0, 1'b0, 10, 0, 0, 60, lat, stable, rdy, bsy);
    chk("r_latency", lat, LAT_C);
    chk("r_dataA", config_dataA, 20'h0F0F0);
    chk("r_dataB", config_dataB, 20'h5A5A5);
    chk("r_no_partial", stable, 1'b1);
    tick;

    // cfg_valid low every other cycle.
    run_load(20'h12345, 20'hABCDE, 1'b1, 1'b0, 0, 0, 0, 120, lat, stable, rdy, bsy);
    chk("g_latency", lat, LAT_G);
    chk("g_dataA", config_dataA, 20'h12345);
    chk("g_dataB", config_dataB, 20'hABCDE);
    chk("g_no_partial", stable, 1'b1);
    tick;
    chk("g_done_one_cycle", cfg_done, 1'b0);

    // Abort after 17 accepted bits, abort on the same edge as bit 17.
    run_load(20'h11111, 20'h22222, 1'b0, 1'b0, 0, 18, 0, 60, lat, stable, rdy, bsy);
    chk("a_busy_next", bsy, 1'b0);
    chk("a_no_done", lat, -1);
    chk("a_keep", stable, 1'b1);
    chk("a_dataA", config_dataA, 20'h12345);
    chk("a_dataB", config_dataB, 20'hABCDE);
    chk("a_cvalid", config_valid, 1'b1);
    chk("a_ready", cfg_ready, 1'b0);

`ifdef CONBOX_CFG_PARITY_EN
    // Wrong parity bit: error, no commit.
    run_load(20'h33333, 20'h44444, 1'b0, 1'b1, 0, 0, 0, 60, lat, stable, rdy, bsy);
    chk("p_err", cfg_err, 1'b1);
    chk("p_no_done", lat, -1);
    chk("p_keep", stable, 1'b1);
    chk("p_busy", cfg_busy, 1'b0);
    cfg_start = 1'b1;
    tick;
    cfg_start = 1'b0;
    chk("p_err_cleared", cfg_err, 1'b0);
    cfg_abort = 1'b1;
    tick;
    cfg_abort = 1'b0;
    chk("p_abort_idle", cfg_busy, 1'b0);
`endif

    // Reset after 30 accepted bits.
    run_load(20'h55555, 20'h66666, 1'b0, 1'b0, 0, 0, 31, 60, lat, stable, rdy, bsy);
    chk("x_no_done", lat, -1);
    chk("x_busy", bsy, 1'b0);
    chk("x_dataA", config_dataA, TIE);
    chk("x_dataB", config_dataB, TIE);
    chk("x_cvalid", config_valid, 1'b0);
    chk("x_ready", cfg_ready, 1'b0);
    chk("x_err", cfg_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
